adc0809_responder: RTL and testbench

- Synthesizable model of the converter side of the ADC0809-style handshake: ALE/START/OE in, EOC and data out.
- Pairs with the team's existing ADC controller FSM in simulation and in FPGA loop-back builds, replacing the physical converter.
- Channel "analog" values arrive as packed digital inputs.
- Converts the addressed channel with programmable timing.

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_edge_det.sv | 21 ++
 rtl/adc0809_responder.sv | 160 ++++++++++++++++
 tb/tb_adc0809_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and default parameters for the ADC0809-style converter
// responder: FSM state encoding, default widths and default timing.
package adc_pkg;

   localparam int DW_DEF       = 8;
   localparam int ADDR_W_DEF   = 2;
   localparam int EOC_DLY_DEF  = 2;
   localparam int CONV_CYC_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      CONV  = 2'd2
   } adc_state_e;

endpackage

// File: rtl/adc_edge_det.sv
// Single-bit registered rising-edge detector. The output is high during the
// cycle in which the input is 1 and its registered copy is still 0.
module adc_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   // Registered copy of the input, cleared by reset so a high level at
   // reset release is seen as an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) d_q <= 1'b0;
      else         d_q <= d_i;
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/adc0809_responder.sv
// Converter side of an ADC0809-style handshake (ALE/START/OE in, EOC and
// data out) used in place of the physical converter. The addressed channel
// is sampled on the START rising edge, EOC falls EOC_DLY cycles later and
// rises CONV_CYC cycles after that, when the result register updates.
// Optional feature macro ADC_OVERRUN_EN adds a sticky 'overrun' output,
// set by a START edge while busy and cleared by a G_D rising edge.
module adc0809_responder
   import adc_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int EOC_DLY  = EOC_DLY_DEF,
   parameter int CONV_CYC = CONV_CYC_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ale,
   input  logic                      start,
   input  logic                      g_d,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [(2**ADDR_W)*DW-1:0] ch_data,
   output logic                      eoc,
   output logic [DW-1:0]             dout,
   output logic                      busy
`ifdef ADC_OVERRUN_EN
   ,
   output logic                      overrun
`endif
);

   localparam int NCH     = 2**ADDR_W;
   localparam int CNT_MAX = (EOC_DLY > CONV_CYC) ? EOC_DLY : CONV_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(EOC_DLY - 1);
   localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONV_CYC - 1);

   logic              ale_rise;
   logic              start_rise;
   adc_state_e        state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              eoc_q,    eoc_d;
   logic [ADDR_W-1:0] addr_l_q, addr_l_d;
   logic [DW-1:0]     sample_q, sample_d;
   logic [DW-1:0]     result_q, result_d;
   logic [ADDR_W-1:0] sel;
   logic [DW-1:0]     ch_sel;

   adc_edge_det u_ale_edge (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (ale),
      .rise_o (ale_rise)
   );

   adc_edge_det u_start_edge (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (start),
      .rise_o (start_rise)
   );

   // Channel select: an address being latched this cycle bypasses addr_l.
   always_comb begin
      sel    = ale_rise ? addr : addr_l_q;
      ch_sel = '0;
      for (int k = 0; k < NCH; k++) begin
         if (sel == ADDR_W'(k)) ch_sel = ch_data[k*DW +: DW];
      end
   end

   // Next-state logic: a START edge always (re)samples and re-enters DELAY;
   // otherwise DELAY and CONV count down to their expiry actions.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      eoc_d    = eoc_q;
      addr_l_d = ale_rise ? addr : addr_l_q;
      sample_d = sample_q;
      result_d = result_q;
      if (start_rise) begin
         sample_d = ch_sel;
         cnt_d    = DLY_LOAD;
         state_d  = DELAY;
      end else begin
         case (state_q)
            DELAY: begin
               if (cnt_q == '0) begin
                  eoc_d   = 1'b0;
                  cnt_d   = CONV_LOAD;
                  state_d = CONV;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            CONV: begin
               if (cnt_q == '0) begin
                  result_d = sample_q;
                  eoc_d    = 1'b1;
                  state_d  = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // State, counter, handshake and data registers; reset discards any
   // conversion in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         eoc_q    <= 1'b1;
         addr_l_q <= '0;
         sample_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         eoc_q    <= eoc_d;
         addr_l_q <= addr_l_d;
         sample_q <= sample_d;
         result_q <= result_d;
      end
   end

   assign eoc  = eoc_q;
   assign busy = (state_q != IDLE);
   assign dout = g_d ? result_q : '0;

`ifdef ADC_OVERRUN_EN
   logic g_d_rise;
   logic overrun_q, overrun_d;

   adc_edge_det u_gd_edge (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (g_d),
      .rise_o (g_d_rise)
   );

   // Sticky overrun flag; a restart in the same cycle as a read wins.
   always_comb begin
      overrun_d = overrun_q;
      if (g_d_rise)           overrun_d = 1'b0;
      if (start_rise && busy) overrun_d = 1'b1;
   end

   // Overrun register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overrun_q <= 1'b0;
      else        overrun_q <= overrun_d;
   end

   assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_adc0809_responder.sv
// Directed self-checking bench for adc0809_responder (default timing:
// EOC_DLY=2, CONV_CYC=8). Overrun checks are compiled in with ADC_OVERRUN_EN.
module tb_adc0809_responder;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        ale     = 1'b0;
   logic        start   = 1'b0;
   logic        g_d     = 1'b0;
   logic [1:0]  addr    = 2'd0;
   logic [31:0] ch_data = 32'h0;
   logic        eoc;
   logic        busy;
   logic [7:0]  dout;
`ifdef ADC_OVERRUN_EN
   logic        overrun;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   adc0809_responder #(
      .DW       (8),
      .ADDR_W   (2),
      .EOC_DLY  (2),
      .CONV_CYC (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ale     (ale),
      .start   (start),
      .g_d     (g_d),
      .addr    (addr),
      .ch_data (ch_data),
      .eoc     (eoc),
      .dout    (dout),
      .busy    (busy)
`ifdef ADC_OVERRUN_EN
      ,
      .overrun (overrun)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic latch(input logic [1:0] a);
      addr = a;
      ale  = 1'b1;
      step();
      ale  = 1'b0;
      step();
   endtask

   // Leaves the bench just after edge 0 of a conversion.
   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Read the result across one clock edge, then check dout returns to 0.
   task automatic read(input string tag, input logic [7:0] exp);
      g_d = 1'b1;
      #1;
      check(tag, dout, exp);
      step();
      check({tag, "_again"}, dout, exp);
      g_d = 1'b0;
      #1;
      check({tag, "_gd0"}, dout, 8'h00);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi_cnt;
      int w;
      logic [7:0] v;

      // Reset state
      step();
      step();
      check("rst_eoc", eoc, 1'b1);
      check("rst_busy", busy, 1'b0);
      g_d = 1'b1;
      #1;
      check("rst_dout", dout, 8'h00);
      g_d = 1'b0;
      reset = 1'b1;
      step();

      // 1: reset mid-conversion
      ch_data = {8'h44, 8'h33, 8'h22, 8'h11};
      latch(2'd2);
      pulse_start();
      repeat (4) step();
      check("t1_conv_eoc", eoc, 1'b0);
      reset = 1'b0;
      #1;
      check("t1_rst_eoc", eoc, 1'b1);
      check("t1_rst_busy", busy, 1'b0);
      g_d = 1'b1;
      #1;
      check("t1_rst_dout", dout, 8'h00);
      g_d = 1'b0;
      step();
      step();
      reset = 1'b1;
      repeat (15) step();
      check("t1_after_eoc", eoc, 1'b1);
      check("t1_after_busy", busy, 1'b0);
      read("t1_after_dout", 8'h00);

      // 2: basic conversion, channel 2
      latch(2'd2);
      pulse_start();
      check("t2_e0_eoc", eoc, 1'b1);
      check("t2_e0_busy", busy, 1'b1);
      for (int e = 1; e <= 10; e++) begin
         step();
         check($sformatf("t2_e%0d_eoc", e), eoc, (e >= 2 && e <= 9) ? 1'b0 : 1'b1);
      end
      check("t2_done_busy", busy, 1'b0);
      read("t2_dout", 8'h33);

      // 3: same-cycle ale and start use the address being latched
      latch(2'd0);
      addr  = 2'd3;
      ale   = 1'b1;
      start = 1'b1;
      step();
      ale   = 1'b0;
      start = 1'b0;
      repeat (10) step();
      check("t3_eoc", eoc, 1'b1);
      read("t3_dout", 8'h44);

      // 4: channel data change after the sample edge is ignored
      ch_data = {8'h44, 8'h33, 8'hA5, 8'h11};
      latch(2'd1);
      pulse_start();
      repeat (3) step();
      ch_data[15:8] = 8'h5A;
      repeat (7) step();
      check("t4_eoc", eoc, 1'b1);
      read("t4_dout", 8'hA5);
      ch_data = {8'h44, 8'h33, 8'h22, 8'h11};

      // 5: restart at edge 6 onto channel 0
      latch(2'd2);
      pulse_start();
      for (int e = 1; e <= 16; e++) begin
         if (e == 6) begin
            addr  = 2'd0;
            ale   = 1'b1;
            start = 1'b1;
         end
         step();
         ale   = 1'b0;
         start = 1'b0;
         check($sformatf("t5_e%0d_eoc", e), eoc, (e >= 2 && e <= 15) ? 1'b0 : 1'b1);
         if (e == 15) check("t5_e15_busy", busy, 1'b1);
         if (e == 16) check("t5_e16_busy", busy, 1'b0);
`ifdef ADC_OVERRUN_EN
         if (e == 5)  check("t5_ovr_before", overrun, 1'b0);
         if (e == 6)  check("t5_ovr_set", overrun, 1'b1);
         if (e == 16) check("t5_ovr_held", overrun, 1'b1);
`endif
      end
      g_d = 1'b1;
      #1;
      check("t5_dout", dout, 8'h11);
      step();
`ifdef ADC_OVERRUN_EN
      check("t5_ovr_clr", overrun, 1'b0);
`endif
      g_d = 1'b0;
      step();

      // Level start: one conversion per rising edge
      hi_cnt = 0;
      start  = 1'b1;
      for (int i = 0; i < 25; i++) begin
         step();
         if (busy) hi_cnt++;
      end
      start = 1'b0;
      step();
      check("lvl_busy_cycles", hi_cnt, 10);
      check("lvl_eoc", eoc, 1'b1);

      // 6: closed loop, 20 conversions of channel 2 with bounded waits
      for (int i = 0; i < 20; i++) begin
         v = 8'h60 + 8'(i * 7);
         ch_data[23:16] = v;
         latch(2'd2);
         pulse_start();
         w = 0;
         while (eoc !== 1'b0 && w < 20) begin
            step();
            w++;
         end
         check($sformatf("t6_%0d_eoc_fall", i), eoc, 1'b0);
         w = 0;
         while (eoc !== 1'b1 && w < 20) begin
            step();
            w++;
         end
         check($sformatf("t6_%0d_eoc_rise", i), eoc, 1'b1);
         read($sformatf("t6_%0d_dout", i), v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
